// File: rtl/flash_cmd_seq.sv
// SPI-flash slave command sequencer.
// Decodes the opcode byte, assembles the address, skips the fast-read dummy
// byte and issues one-cycle array read/write and status strobes. It also owns
// the write-enable latch.
//
// Handshake: a byte is accepted only on an sck edge where data_in_valid=1 and
// cs_n=0. Every strobe is a one-cycle pulse that rises on the edge accepting
// its byte. mem_addr and mem_wdata hold their value between strobes.
// cs_n=1 always wins over data_in_valid.
module flash_cmd_seq #(
  parameter int ADDR_BYTES = 3,
  parameter int PAGE_BITS  = 8,
  parameter int AW         = 8 * ADDR_BYTES
) (
  input  logic          sck,
  input  logic          rst,
  input  logic          cs_n,
  input  logic [7:0]    data_byte_in,
  input  logic          data_in_valid,
  output logic [7:0]    cmd,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata,
  output logic          status_rd,
  output logic          wel,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  localparam int CW = $clog2(ADDR_BYTES + 1);

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_FREAD = 8'h0B;
  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DUMMY   = 3'd2,
    S_RD_DATA = 3'd3,
    S_WR_DATA = 3'd4,
    S_STAT    = 3'd5,
    S_IGNORE  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [AW-1:0] addr_q, addr_d;        // assembly register, then write pointer
  logic [CW-1:0] cnt_q, cnt_d;          // address bytes received
  logic          rd_en_q, rd_en_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          stat_q, stat_d;
  logic          wel_q, wel_d;
  logic          busy_q, busy_d;
  logic          wrote_q, wrote_d;      // at least one byte programmed this transaction

  logic [AW-1:0]        addr_asm;
  logic [PAGE_BITS-1:0] page_lo_nxt;

  assign addr_asm    = (addr_q << 8) | AW'(data_byte_in);
  assign page_lo_nxt = addr_q[PAGE_BITS-1:0] + PAGE_BITS'(1);

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    mem_addr_d = mem_addr_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    wdata_d    = wdata_q;
    stat_d     = 1'b0;
    wel_d      = wel_q;
    wrote_d    = wrote_q;

    if (cs_n) begin
      // End of transaction: any byte arriving on this edge is dropped.
      state_d = S_IDLE;
      cnt_d   = '0;
      wrote_d = 1'b0;
      if (state_q == S_WR_DATA && wrote_q) wel_d = 1'b0;
    end else if (data_in_valid) begin
      unique case (state_q)
        S_IDLE: begin
          cmd_d  = data_byte_in;
          cnt_d  = '0;
          addr_d = '0;
          case (data_byte_in)
            OP_READ, OP_FREAD: state_d = S_ADDR;
            OP_PP:             state_d = wel_q ? S_ADDR : S_IGNORE;
            OP_WREN: begin
              wel_d   = 1'b1;
              state_d = S_IGNORE;
            end
            OP_WRDI: begin
              wel_d   = 1'b0;
              state_d = S_IGNORE;
            end
            OP_RDSR: begin
              stat_d  = 1'b1;
              state_d = S_STAT;
            end
            default: state_d = S_IGNORE;
          endcase
        end
        S_ADDR: begin
          addr_d = addr_asm;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(ADDR_BYTES - 1)) begin
            case (cmd_q)
              OP_READ: begin
                state_d    = S_RD_DATA;
                mem_addr_d = addr_asm;
                rd_en_d    = 1'b1;
              end
              OP_FREAD: state_d = S_DUMMY;
              default:  state_d = S_WR_DATA;
            endcase
          end
        end
        S_DUMMY: begin
          state_d    = S_RD_DATA;
          mem_addr_d = addr_q;
          rd_en_d    = 1'b1;
        end
        S_RD_DATA: begin
          mem_addr_d = mem_addr_q + AW'(1);
          rd_en_d    = 1'b1;
        end
        S_WR_DATA: begin
          // Present the current address, then advance within the page only.
          mem_addr_d = addr_q;
          wdata_d    = data_byte_in;
          wr_en_d    = 1'b1;
          wrote_d    = 1'b1;
          addr_d     = {addr_q[AW-1:PAGE_BITS], page_lo_nxt};
        end
        S_STAT:   stat_d = 1'b1;
        S_IGNORE: state_d = S_IGNORE;
        default:  state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      mem_addr_q <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wdata_q    <= '0;
      stat_q     <= 1'b0;
      wel_q      <= 1'b0;
      busy_q     <= 1'b0;
      wrote_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      mem_addr_q <= mem_addr_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      wdata_q    <= wdata_d;
      stat_q     <= stat_d;
      wel_q      <= wel_d;
      busy_q     <= busy_d;
      wrote_q    <= wrote_d;
    end
  end

  assign cmd       = cmd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd_en = rd_en_q;
  assign mem_wr_en = wr_en_q;
  assign mem_wdata = wdata_q;
  assign status_rd = stat_q;
  assign wel       = wel_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Bench for flash_cmd_seq: directed byte streams, expected strobes queued
// as they are issued and checked by an independent monitor.
module tb_flash_cmd_seq;

  localparam int AW = 24;

  localparam logic [1:0] K_RD   = 2'd1;
  localparam logic [1:0] K_WR   = 2'd2;
  localparam logic [1:0] K_STAT = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  logic          sck;
  logic          rst;
  logic          cs_n;
  logic [7:0]    data_byte_in;
  logic          data_in_valid;
  logic [7:0]    cmd;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [7:0]    mem_wdata;
  logic          status_rd;
  logic          wel;
  logic          busy;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // expected event: {kind[1:0], addr[23:0], data[7:0]}
  logic [33:0] exp_q[$];

  flash_cmd_seq dut (
    .sck(sck), .rst(rst), .cs_n(cs_n), .data_byte_in(data_byte_in),
    .data_in_valid(data_in_valid), .cmd(cmd), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .status_rd(status_rd), .wel(wel), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial sck = 1'b0;
  always #5 sck = ~sck;

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge sck);
    data_byte_in  = b;
    data_in_valid = 1'b1;
    @(negedge sck);
    data_in_valid = 1'b0;
    data_byte_in  = 8'h00;
    for (int i = 0; i < gap; i++) @(negedge sck);
  endtask

  task automatic end_cs();
    @(negedge sck);
    cs_n = 1'b1;
    @(negedge sck);
    cs_n = 1'b0;
  endtask

  task automatic push_rd(input logic [AW-1:0] a);
    exp_q.push_back({K_RD, a, 8'h00});
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
    exp_q.push_back({K_WR, a, d});
  endtask

  task automatic push_stat();
    exp_q.push_back({K_STAT, 24'h0, 8'h00});
  endtask

  // Direct check, called at a negedge with outputs settled.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge sck) begin
    logic [1:0]  kind;
    logic [33:0] e;
    kind = 2'd0;
    if (!rst && (mem_rd_en || mem_wr_en || status_rd)) begin
      if ((mem_rd_en + mem_wr_en + status_rd) > 1) kind = 2'd0;
      else if (mem_rd_en) kind = K_RD;
      else if (mem_wr_en) kind = K_WR;
      else                kind = K_STAT;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: kind %0d addr 0x%0h, none expected", kind, mem_addr);
      end else begin
        e = exp_q.pop_front();
        if (kind !== e[33:32]) begin
          n_fail++;
          $display("FAIL strobe_kind: got %0d expected %0d", kind, e[33:32]);
        end else if (kind != K_STAT && mem_addr !== e[31:8]) begin
          n_fail++;
          $display("FAIL strobe_addr: got 0x%0h expected 0x%0h", mem_addr, e[31:8]);
        end else if (kind == K_WR && mem_wdata !== e[7:0]) begin
          n_fail++;
          $display("FAIL strobe_wdata: got 0x%0h expected 0x%0h", mem_wdata, e[7:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; cs_n = 1'b1; data_byte_in = 8'h00; data_in_valid = 1'b0;
    repeat (3) @(negedge sck);
    check("rst_cmd",   {24'h0, cmd}, 32'h0);
    check("rst_addr",  {8'h0, mem_addr}, 32'h0);
    check("rst_strb",  {29'h0, mem_rd_en, mem_wr_en, status_rd}, 32'h0);
    check("rst_wdata", {24'h0, mem_wdata}, 32'h0);
    check("rst_wel_busy", {30'h0, wel, busy}, 32'h0);
    rst = 1'b0;
    @(negedge sck);
    cs_n = 1'b0;
    @(negedge sck);

    // READ 0x123456 with idle gaps inside the stream
    send_byte(8'h03, 2);
    check("read_cmd", {24'h0, cmd}, 32'h03);
    send_byte(8'h12, 0);
    send_byte(8'h34, 3);
    push_rd(24'h123456); send_byte(8'h56, 2);
    push_rd(24'h123457); send_byte(8'h00, 0);
    push_rd(24'h123458); send_byte(8'h00, 4);
    check("read_addr_hold", {8'h0, mem_addr}, 32'h123458);
    end_cs();
    check("read_idle_busy", {31'h0, busy}, 32'h0);

    // FAST_READ with full-width address wrap
    send_byte(8'h0B, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    push_rd(24'hFFFFFF); send_byte(8'hA5, 0);
    push_rd(24'h000000); send_byte(8'h00, 0);
    end_cs();

    // WREN then PAGE_PROGRAM across a page boundary
    send_byte(8'h06, 0);
    end_cs();
    check("wren_wel", {31'h0, wel}, 32'h1);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'hFE, 0);
    push_wr(24'h0010FE, 8'hA1); send_byte(8'hA1, 0);
    push_wr(24'h0010FF, 8'hA2); send_byte(8'hA2, 1);
    push_wr(24'h001000, 8'hA3); send_byte(8'hA3, 0);
    check("pp_wel_before_cs", {31'h0, wel}, 32'h1);
    end_cs();
    check("pp_wel_autoclear", {31'h0, wel}, 32'h0);

    // PAGE_PROGRAM without WREN is ignored
    send_byte(8'h02, 0);
    check("pp_nowel_state", {29'h0, dbg_state}, {29'h0, ST_IGNORE});
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h55, 0);
    check("pp_nowel_wel", {31'h0, wel}, 32'h0);
    end_cs();

    // RDSR status stream
    push_stat(); send_byte(8'h05, 0);
    push_stat(); send_byte(8'hC3, 0);
    push_stat(); send_byte(8'h3C, 0);
    end_cs();

    // Unknown opcode
    send_byte(8'h9F, 0);
    check("unk_state", {29'h0, dbg_state}, {29'h0, ST_IGNORE});
    check("unk_cmd", {24'h0, cmd}, 32'h9F);
    send_byte(8'h11, 0);
    end_cs();
    check("unk_idle", {29'h0, dbg_state}, {29'h0, ST_IDLE});

    // WRDI clears the latch
    send_byte(8'h06, 0);
    end_cs();
    send_byte(8'h04, 0);
    check("wrdi_wel", {31'h0, wel}, 32'h0);
    end_cs();

    // Reset in the middle of a READ, with wel set
    send_byte(8'h06, 0);
    end_cs();
    send_byte(8'h03, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    @(negedge sck);
    rst = 1'b1;
    @(negedge sck);
    check("abort_cmd",  {24'h0, cmd}, 32'h0);
    check("abort_addr", {8'h0, mem_addr}, 32'h0);
    check("abort_wel_busy", {30'h0, wel, busy}, 32'h0);
    rst = 1'b0;
    @(negedge sck);

    // cs_n together with data_in_valid in WR_DATA: no write, wel kept
    send_byte(8'h06, 0);
    end_cs();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h20, 0);
    send_byte(8'h00, 0);
    @(negedge sck);
    cs_n = 1'b1; data_byte_in = 8'h77; data_in_valid = 1'b1;
    @(negedge sck);
    data_in_valid = 1'b0;
    check("cs_win_busy", {31'h0, busy}, 32'h0);
    check("cs_win_wel", {31'h0, wel}, 32'h1);
    cs_n = 1'b0;
    repeat (4) @(negedge sck);

    // final report
    check("exp_q_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
